// File: rtl/coef_ram_pkg.sv
// rtl/coef_ram_pkg.sv - shared types and constants for the coefficient RAM loader
// Sizes derive from the 16k-deep, 36-bit dual-channel coefficient RAM.
package coef_ram_pkg;

  localparam int COEF_W         = 36;
  localparam int RAM_DEPTH      = 16384;
  localparam int ADDR_W         = $clog2(RAM_DEPTH);
  localparam int CNT_W          = ADDR_W + 1;
  localparam int BYTES_PER_WORD = 5;
  localparam int SHIFT_W        = 8 * BYTES_PER_WORD;

  typedef enum logic [2:0] {
    IDLE,
    WR_COLLECT,
    WR_COMMIT,
    RD_ADDR,
    RD_WAIT,
    RD_SEND,
    DONE
  } loaderState;

endpackage

// File: rtl/coef_byte_shifter.sv
// rtl/coef_byte_shifter.sv - 40-bit byte load/shift register with byte counter
// Shared by write assembly (bytes shifted in) and readback serialisation (bytes shifted out).
module coef_byte_shifter
  import coef_ram_pkg::*;
(
  input  logic               clock,
  input  logic               reset,
  input  logic               clear,
  input  logic               load,
  input  logic               shift,
  input  logic [SHIFT_W-1:0] loadData,
  input  logic [7:0]         shiftIn,
  output logic [7:0]         outByte,
  output logic [COEF_W-1:0]  assembled,
  output logic               firstByte,
  output logic               lastByte
);

  logic [SHIFT_W-1:0] shiftReg;
  logic [2:0]         byteCnt;

  always_ff @(posedge clock) begin
    if (reset || clear) begin
      shiftReg <= '0;
      byteCnt  <= '0;
    end else if (load) begin
      shiftReg <= loadData;
      byteCnt  <= '0;
    end else if (shift) begin
      shiftReg <= {shiftReg[SHIFT_W-9:0], shiftIn};
      byteCnt  <= lastByte ? 3'd0 : byteCnt + 3'd1;
    end
  end

  assign outByte   = shiftReg[SHIFT_W-1 -: 8];
  // Full word as it will stand once the byte currently on shiftIn is taken.
  assign assembled = {shiftReg[COEF_W-9:0], shiftIn};
  assign firstByte = (byteCnt == 3'd0);
  assign lastByte  = (byteCnt == 3'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/coef_ram_loader.sv
// rtl/coef_ram_loader.sv - host byte-stream writer/reader for the dual-channel coefficient RAM
// Optional running byte checksum enabled by COEF_RAM_LOADER_CHECKSUM_EN.
module coef_ram_loader
  import coef_ram_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              mode,
  input  logic              chan,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [CNT_W-1:0]  count,
  input  logic              abort,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [7:0]        out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] addrLrw,
  output logic [ADDR_W-1:0] addrRrw,
  output logic [COEF_W-1:0] datainLrw,
  output logic [COEF_W-1:0] datainRrw,
  output logic              weL,
  output logic              weR,
  input  logic [COEF_W-1:0] dataoutLrw,
  input  logic [COEF_W-1:0] dataoutRrw,
  output logic              busy,
  output logic              done,
  output logic              fmt_err,
  output logic [15:0]       checksum
);

  loaderState          state, nextState;
  logic                chanReg;
  logic [ADDR_W-1:0]   addrReg;
  logic [CNT_W-1:0]    remaining;
  logic [COEF_W-1:0]   datainReg;
  logic                fmtErr;

  logic                shClear, shLoad, shShift;
  logic [7:0]          shIn, outByte;
  logic [COEF_W-1:0]   assembled;
  logic                firstByte, lastByte;

  logic startAccept, abortNow, inAccept, outAccept, advance, lastWord;

  assign startAccept = (state == IDLE) && start;
  assign abortNow    = abort && (state != IDLE) && (state != DONE);
  assign inAccept    = (state == WR_COLLECT) && in_valid;
  assign outAccept   = (state == RD_SEND) && out_ready;
  assign lastWord    = (remaining == CNT_W'(1));
  assign advance     = !abortNow && ((state == WR_COMMIT) || (outAccept && lastByte));

  coef_byte_shifter shifter (
    .clock     (clock),
    .reset     (reset),
    .clear     (shClear),
    .load      (shLoad),
    .shift     (shShift),
    .loadData  ({4'h0, chanReg ? dataoutRrw : dataoutLrw}),
    .shiftIn   (shIn),
    .outByte   (outByte),
    .assembled (assembled),
    .firstByte (firstByte),
    .lastByte  (lastByte)
  );

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= nextState;
  end

  always_comb begin
    nextState = state;
    shClear   = 1'b0;
    shLoad    = 1'b0;
    shShift   = 1'b0;
    shIn      = 8'h00;
    case (state)
      IDLE: begin
        if (start) begin
          shClear = 1'b1;
          if (count == '0) nextState = DONE;
          else if (mode)   nextState = RD_ADDR;
          else             nextState = WR_COLLECT;
        end
      end
      WR_COLLECT: begin
        shIn    = in_data;
        shShift = in_valid;
        if (in_valid && lastByte) nextState = WR_COMMIT;
      end
      WR_COMMIT: nextState = lastWord ? DONE : WR_COLLECT;
      RD_ADDR:   nextState = RD_WAIT;
      RD_WAIT: begin
        shLoad    = 1'b1;
        nextState = RD_SEND;
      end
      RD_SEND: begin
        shShift = out_ready;
        if (out_ready && lastByte) nextState = lastWord ? DONE : RD_ADDR;
      end
      DONE:    nextState = IDLE;
      default: nextState = IDLE;
    endcase
    // Cancelling discards any partial word held in the shifter.
    if (abortNow) begin
      nextState = DONE;
      shClear   = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      chanReg   <= 1'b0;
      addrReg   <= '0;
      remaining <= '0;
      datainReg <= '0;
      fmtErr    <= 1'b0;
    end else begin
      if (startAccept) begin
        chanReg   <= chan;
        addrReg   <= base_addr;
        remaining <= count;
        fmtErr    <= 1'b0;
      end
      if (inAccept && firstByte && (in_data[7:4] != 4'h0)) fmtErr <= 1'b1;
      if (inAccept && lastByte) datainReg <= assembled;
      // Address wraps naturally at the 14-bit boundary.
      if (advance) begin
        addrReg   <= addrReg + ADDR_W'(1);
        remaining <= remaining - CNT_W'(1);
      end
    end
  end

  assign in_ready  = (state == WR_COLLECT);
  assign out_valid = (state == RD_SEND);
  assign out_data  = out_valid ? outByte : 8'h00;
  assign addrLrw   = addrReg;
  assign addrRrw   = addrReg;
  assign datainLrw = datainReg;
  assign datainRrw = datainReg;
  assign weL       = (state == WR_COMMIT) && !chanReg;
  assign weR       = (state == WR_COMMIT) && chanReg;
  assign busy      = (state != IDLE);
  assign done      = (state == DONE);
  assign fmt_err   = fmtErr;

`ifdef COEF_RAM_LOADER_CHECKSUM_EN
  logic [15:0] sumReg;

  always_ff @(posedge clock) begin
    if (reset || startAccept) sumReg <= '0;
    else if (inAccept)        sumReg <= sumReg + 16'(in_data);
    else if (outAccept)       sumReg <= sumReg + 16'(outByte);
  end

  assign checksum = sumReg;
`else
  assign checksum = 16'h0000;
`endif

endmodule

// File: tb/tb_coef_ram_loader.sv
// tb/tb_coef_ram_loader.sv - self-checking bench for coef_ram_loader
// Expected checksums depend on COEF_RAM_LOADER_CHECKSUM_EN.
module tb_coef_ram_loader;

  logic        clock = 1'b0;
  logic        reset, start, mode, chan, abort, in_valid, out_ready;
  logic [13:0] base_addr;
  logic [14:0] count;
  logic [7:0]  in_data, out_data;
  logic        in_ready, out_valid, weL, weR, busy, done, fmt_err;
  logic [13:0] addrLrw, addrRrw;
  logic [35:0] datainLrw, datainRrw, dataoutLrw, dataoutRrw;
  logic [15:0] checksum;

  int nChecks = 0;
  int nFail   = 0;

`ifdef COEF_RAM_LOADER_CHECKSUM_EN
  localparam bit CK = 1'b1;
`else
  localparam bit CK = 1'b0;
`endif

  always #5 clock = ~clock;

  coef_ram_loader dut (
    .clock(clock), .reset(reset), .start(start), .mode(mode), .chan(chan),
    .base_addr(base_addr), .count(count), .abort(abort),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .addrLrw(addrLrw), .addrRrw(addrRrw), .datainLrw(datainLrw), .datainRrw(datainRrw),
    .weL(weL), .weR(weR), .dataoutLrw(dataoutLrw), .dataoutRrw(dataoutRrw),
    .busy(busy), .done(done), .fmt_err(fmt_err), .checksum(checksum)
  );

  // Dual-channel RAM model with 1-cycle registered read.
  logic [35:0] memL [0:16383];
  logic [35:0] memR [0:16383];
  always @(posedge clock) begin
    if (weL) memL[addrLrw] <= datainLrw;
    if (weR) memR[addrRrw] <= datainRrw;
    dataoutLrw <= memL[addrLrw];
    dataoutRrw <= memR[addrRrw];
  end

  typedef struct {logic ch; logic [13:0] addr; logic [35:0] data;} wrRec;
  wrRec wlog[$];
  int bothWe = 0;
  always @(negedge clock) begin
    if (weL || weR) begin
      wlog.push_back('{weR, addrLrw, datainLrw});
      if (weL && weR) bothWe++;
    end
  end

  typedef struct {logic ch; logic [13:0] base; logic [39:0] bytes; logic [35:0] expData; logic expFmt;} vecT;
  vecT vecs[4];

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic doStart(input logic m, input logic c, input logic [13:0] b, input logic [14:0] n);
    mode = m; chan = c; base_addr = b; count = n; start = 1'b1;
    tick;
    start = 1'b0;
  endtask

  task automatic sendByte(input logic [7:0] b);
    int n;
    n = 0;
    in_data = b; in_valid = 1'b1;
    while (!in_ready && n < 20) begin tick; n++; end
    check("in_ready_wait", in_ready, 1);
    tick;
    in_valid = 1'b0;
  endtask

  task automatic recvByte(input string nm, input logic [7:0] exp, input int stall);
    int n;
    n = 0;
    out_ready = 1'b0;
    while (!out_valid && n < 20) begin tick; n++; end
    check({nm, "_valid"}, out_valid, 1);
    for (int s = 0; s < stall; s++) begin
      check({nm, "_stall"}, out_data, exp);
      tick;
    end
    check(nm, out_data, exp);
    out_ready = 1'b1;
    tick;
    out_ready = 1'b0;
  endtask

  task automatic waitDone(input string nm);
    int n;
    n = 0;
    while (!done && n < 60) begin tick; n++; end
    check({nm, "_done"}, done, 1);
  endtask

  task automatic checkWrite(input string nm, input int idx, input logic ch, input logic [13:0] a, input logic [35:0] d);
    check({nm, "_present"}, 64'(wlog.size() > idx), 1);
    if (wlog.size() > idx) begin
      check({nm, "_chan"}, wlog[idx].ch, ch);
      check({nm, "_addr"}, wlog[idx].addr, a);
      check({nm, "_data"}, wlog[idx].data, d);
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0;
    logic [39:0] w;

    vecs[0] = '{1'b0, 14'h0040, 40'h0F12345678, 36'hF12345678, 1'b0};
    vecs[1] = '{1'b1, 14'h0041, 40'hF100000001, 36'h100000001, 1'b1};
    vecs[2] = '{1'b1, 14'h3FFE, 40'h00FFFFFFFF, 36'h0FFFFFFFF, 1'b0};
    vecs[3] = '{1'b0, 14'h0000, 40'h5AA55AA55A, 36'hAA55AA55A, 1'b1};

    reset = 1'b1; start = 1'b0; mode = 1'b0; chan = 1'b0; abort = 1'b0;
    base_addr = '0; count = '0; in_data = '0; in_valid = 1'b0; out_ready = 1'b0;
    repeat (3) tick;
    reset = 1'b0;
    check("rst_busy", busy, 0);       check("rst_done", done, 0);
    check("rst_in_ready", in_ready, 0); check("rst_out_valid", out_valid, 0);
    check("rst_we", {weL, weR}, 0);   check("rst_addr", addrLrw, 0);
    check("rst_datain", datainLrw, 0); check("rst_fmt_err", fmt_err, 0);
    check("rst_checksum", checksum, 0); check("rst_out_data", out_data, 0);

    // Two-word write to left channel
    n0 = wlog.size();
    doStart(0, 0, 14'h0005, 2);
    check("a_busy", busy, 1);
    sendByte(8'h0F); sendByte(8'h12); sendByte(8'h34); sendByte(8'h56); sendByte(8'h78);
    sendByte(8'h01); sendByte(8'h00); sendByte(8'h00); sendByte(8'h00); sendByte(8'h01);
    waitDone("a");
    check("a_fmt_err", fmt_err, 0);
    tick;
    check("a_busy_after", busy, 0);
    check("a_nwrites", wlog.size() - n0, 2);
    checkWrite("a_w0", n0, 0, 14'h0005, 36'hF12345678);
    checkWrite("a_w1", n0 + 1, 0, 14'h0006, 36'h100000001);

    // Right channel, format error, address wrap
    n0 = wlog.size();
    doStart(0, 1, 14'h3FFF, 2);
    sendByte(8'hA3); sendByte(8'h11); sendByte(8'h22); sendByte(8'h33); sendByte(8'h44);
    sendByte(8'h00); sendByte(8'h00); sendByte(8'h00); sendByte(8'h00); sendByte(8'h07);
    waitDone("b");
    check("b_fmt_err", fmt_err, 1);
    check("b_checksum", checksum, CK ? 16'h0154 : 16'h0000);
    tick;
    checkWrite("b_w0", n0, 1, 14'h3FFF, 36'h311223344);
    checkWrite("b_w1", n0 + 1, 1, 14'h0000, 36'h000000007);

    // Read the wrapped pair back
    doStart(1, 1, 14'h3FFF, 2);
    recvByte("b_rd0", 8'h03, 0); recvByte("b_rd1", 8'h11, 0); recvByte("b_rd2", 8'h22, 0);
    recvByte("b_rd3", 8'h33, 0); recvByte("b_rd4", 8'h44, 0);
    recvByte("b_rd5", 8'h00, 0); recvByte("b_rd6", 8'h00, 0); recvByte("b_rd7", 8'h00, 0);
    recvByte("b_rd8", 8'h00, 0); recvByte("b_rd9", 8'h07, 0);
    waitDone("b_rd");
    check("b_rd_fmt_clear", fmt_err, 0);
    check("b_rd_addr_end", addrRrw, 14'h0001);
    tick;

    // Readback with stalls and stable address through RD_WAIT
    doStart(0, 0, 14'h0100, 1);
    sendByte(8'h0A); sendByte(8'hBC); sendByte(8'hDE); sendByte(8'hF0); sendByte(8'h12);
    waitDone("c_wr");
    tick;
    doStart(1, 0, 14'h0100, 1);
    check("c_addr_rdaddr", addrLrw, 14'h0100); check("c_ov_rdaddr", out_valid, 0);
    tick;
    check("c_addr_rdwait", addrLrw, 14'h0100); check("c_ov_rdwait", out_valid, 0);
    recvByte("c_b0", 8'h0A, 0); recvByte("c_b1", 8'hBC, 1); recvByte("c_b2", 8'hDE, 0);
    recvByte("c_b3", 8'hF0, 1); recvByte("c_b4", 8'h12, 0);
    waitDone("c_rd");
    check("c_checksum", checksum, CK ? 16'h02A6 : 16'h0000);
    tick;

    // Table of single-word write + readback vectors
    for (int i = 0; i < 4; i++) begin
      n0 = wlog.size();
      doStart(0, vecs[i].ch, vecs[i].base, 1);
      for (int k = 0; k < 5; k++) sendByte(vecs[i].bytes[39-8*k -: 8]);
      waitDone($sformatf("t%0d_wr", i));
      check($sformatf("t%0d_fmt_err", i), fmt_err, vecs[i].expFmt);
      tick;
      checkWrite($sformatf("t%0d_w", i), n0, vecs[i].ch, vecs[i].base, vecs[i].expData);
      doStart(1, vecs[i].ch, vecs[i].base, 1);
      w = {4'h0, vecs[i].expData};
      for (int k = 0; k < 5; k++) recvByte($sformatf("t%0d_rd%0d", i, k), w[39-8*k -: 8], i % 2);
      waitDone($sformatf("t%0d_rd", i));
      tick;
    end

    // Abort after 3 bytes of the second word
    n0 = wlog.size();
    doStart(0, 0, 14'h0020, 4);
    sendByte(8'h01); sendByte(8'h02); sendByte(8'h03); sendByte(8'h04); sendByte(8'h05);
    sendByte(8'h06); sendByte(8'h07); sendByte(8'h08);
    abort = 1'b1;
    tick;
    abort = 1'b0;
    check("d_done", done, 1);
    check("d_we", {weL, weR}, 0);
    tick;
    check("d_busy_after", busy, 0);
    check("d_nwrites", wlog.size() - n0, 1);
    checkWrite("d_w0", n0, 0, 14'h0020, 36'h102030405);

    // count==0 accepted right after the abort; start while busy ignored
    n0 = wlog.size();
    doStart(0, 0, 14'h1234, 0);
    check("e_done", done, 1);
    check("e_busy", busy, 1);
    mode = 1'b0; chan = 1'b1; base_addr = 14'h0555; count = 15'd3; start = 1'b1;
    tick;
    start = 1'b0;
    check("e_idle", busy, 0);
    check("e_done_pulse", done, 0);
    check("e_addr_kept", addrLrw, 14'h1234);
    tick;
    check("e_still_idle", busy, 0);
    check("e_nwrites", wlog.size() - n0, 0);

    // Reset mid-transfer discards the partial word
    n0 = wlog.size();
    doStart(0, 0, 14'h0200, 1);
    sendByte(8'h0E); sendByte(8'hEE);
    reset = 1'b1;
    tick;
    reset = 1'b0;
    check("f_busy", busy, 0); check("f_in_ready", in_ready, 0);
    check("f_addr", addrLrw, 0); check("f_datain", datainLrw, 0);
    doStart(0, 0, 14'h0200, 1);
    sendByte(8'h0C); sendByte(8'h11); sendByte(8'h22); sendByte(8'h33); sendByte(8'h44);
    waitDone("f");
    tick;
    check("f_nwrites", wlog.size() - n0, 1);
    checkWrite("f_w0", n0, 0, 14'h0200, 36'hC11223344);

    // Checksum of 0F,FF,FF,FF,FF and hold after DONE
    doStart(0, 1, 14'h0010, 1);
    sendByte(8'h0F); sendByte(8'hFF); sendByte(8'hFF); sendByte(8'hFF); sendByte(8'hFF);
    waitDone("g");
    check("g_checksum", checksum, CK ? 16'h040B : 16'h0000);
    tick; tick;
    check("g_checksum_hold", checksum, CK ? 16'h040B : 16'h0000);

    check("never_both_we", bothWe, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule

// File: doc/coef_ram_loader.md
Name: coef_ram_loader

Overview:
- Host-side writer/reader for the dual-channel 16k x 36-bit FIR coefficient RAM write/readback port.
- Write mode: accepts a byte stream from the host-interface and assembles 36-bit coefficients. Drives the RAM write port with auto-incrementing addresses.
- Readback mode: reads coefficients back through the same port and serialises them to a byte stream.
- Sits between the host command decoder and the coefficient RAM. Leaves the filter's coefficient read port untouched.

Parameters:
- BYTES_PER_WORD, 5, bytes per 36-bit coefficient; fixed, since 5 x 8 covers 36.
- ADDR_W, 14, RAM write/readback address width.
- CNT_W, 15, transfer word-count width; counts 0..16384.

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle command strobe; sampled only in IDLE.
- mode  in  1  0 = write, 1 = readback; sampled with start.
- chan  in  1  0 = left, 1 = right; sampled with start.
- base_addr  in  14  first word address; sampled with start.
- count  in  15  number of words; sampled with start.
- abort  in  1  cancel the current transfer.
- in_data  in  8  write byte stream.
- in_valid  in  1  in_data valid.
- in_ready  out  1  loader accepts in_data.
- out_data  out  8  readback byte stream.
- out_valid  out  1  out_data valid.
- out_ready  in  1  host accepts out_data.
- addrLrw, addrRrw  out  14  RAM address; both driven from the same internal register.
- datainLrw, datainRrw  out  36  RAM write data; both driven from the same internal register.
- weL, weR  out  1  RAM write enables; only the selected channel is ever asserted.
- dataoutLrw, dataoutRrw  in  36  RAM readback data, 1-cycle registered latency.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse when a transfer completes or is aborted.
- fmt_err  out  1  sticky format-error flag; cleared on an accepted start.
- checksum  out  16  running byte sum (optional feature).

Behaviour:
- Reset: next state IDLE. All outputs 0: addresses, datain, we, in_ready, out_valid, out_data, busy, done, fmt_err, checksum. Internal counters are cleared.
- Reset in the middle of an operation has the same effect; any partial word is discarded.
- IDLE:
  - When start=1, latch mode, chan, base_addr and count.
  - If count==0: go to DONE.
  - Else if mode=0: go to WR_COLLECT.
  - Else: go to RD_ADDR.
- start outside IDLE is ignored.
- WR_COLLECT:
  - in_ready=1. A byte is accepted when in_valid && in_ready.
  - Bytes arrive big-endian. Byte 0 bits[3:0] map to data[35:32]; byte 4 is data[7:0].
  - If byte 0 bits[7:4] are nonzero, set fmt_err and ignore those bits.
  - After the 5th accepted byte, go to WR_COMMIT.
- WR_COMMIT:
  - in_ready=0. Assert we for the latched channel for exactly one cycle, with the current address and word.
  - Then increment the address (14-bit wrap, 16383 -> 0) and decrement the remaining count.
  - If remaining reaches 0: go to DONE. Else: go to WR_COLLECT.
  - Cost: 6 cycles per word minimum.
- RD_ADDR: address is stable; the RAM samples it at the end of this cycle. Go to RD_WAIT.
- RD_WAIT:
  - The selected dataout is valid during this cycle. The address must not change, because the RAM's output mux decodes it.
  - Capture dataout into the shift register; go to RD_SEND.
- RD_SEND:
  - out_valid=1; out_data is the current byte, big-endian. Byte 0 is {4'b0, data[35:32]}.
  - Shift on each out_ready handshake.
  - out_data stays stable while out_valid && !out_ready.
  - After 5 bytes: increment the address and decrement the count, using the same wrap rule as write. Then go to DONE or RD_ADDR.
- DONE: done=1 for one cycle, then go to IDLE. busy is 1 in DONE.
- abort in any non-IDLE state:
  - Go to DONE on the next edge.
  - No further we; a we already asserted in WR_COMMIT in the same cycle still completes.
  - Partial words and unsent bytes are discarded.
  - abort has priority over all other transitions.
- we is never asserted outside WR_COMMIT and never for the unselected channel.

Optional Feature:
- Macro: COEF_RAM_LOADER_CHECKSUM_EN.
- With the macro: checksum is a 16-bit modulo sum of every byte accepted (write) or sent (readback). It is cleared on an accepted start and holds after DONE.
- Without the macro: checksum is tied to 0 and no adder is synthesised.

Decomposition:
- Shared package coef_ram_pkg contains:
  - the state enum: IDLE, WR_COLLECT, WR_COMMIT, RD_ADDR, RD_WAIT, RD_SEND, DONE;
  - constants COEF_W=36, ADDR_W=14, BYTES_PER_WORD=5;
  - the RAM depth 16384.
- One natural sub-module: coef_byte_shifter, the 40-bit load/shift register with byte counter, shared by both directions.

Test Plan:
- Write, chan=0, base=0x0005, count=2, bytes 0F,12,34,56,78 then 01,00,00,00,01:
  - weL pulses twice: addr 5 with data 0xF12345678, then addr 6 with data 0x100000001.
  - weR stays 0; done pulses; fmt_err stays 0.
- Write, chan=1, base=0x3FFF, count=2, first byte 0xA3:
  - fmt_err=1; first word's data[35:32]=3.
  - Second write lands at addr 0x0000 (wrap).
- Readback, chan=0, count=1, RAM word 0xABCDEF012, out_ready toggling 1,0,1:
  - Bytes 0A,BC,DE,F0,12 in order, each held stable while stalled; address constant through RD_WAIT.
- Abort after 3 bytes of the 2nd word (count=4):
  - Exactly 1 write occurred; done pulses the next cycle; busy=0 after.
  - A new start is accepted the following cycle.
- count=0 with start:
  - DONE on the next cycle, no we; start asserted while busy is ignored, and the latched base_addr is unchanged.
- COEF_RAM_LOADER_CHECKSUM_EN, write of bytes 0F,FF,FF,FF,FF:
  - checksum=0x040B (0x0F + 4 x 0xFF); without the macro, checksum stays 0.
